alarm_scheduler: RTL and testbench
==================================

# alarm_scheduler

Controller for the alarm function of the 24-hour BCD clock. It owns the alarm hour/minute registers and loads them from the switch bank. It watches the running time from the clock datapath and sequences the buzzer through ring, snooze and timeout. It sits beside the clock counter at top level and replaces the fixed alarm constants. It drives A_HOUR/A_MIN and BUZZER.

## Interface
- DEBOUNCE_CYCLES, 500000: cycles a synced key level must be stable before it is accepted (10 ms at 50 MHz).
- TONE_DIV, 25000: buzzer half-period in cycles (1 kHz tone).
- SNOOZE_MIN, 5: snooze length in minutes.
- RING_TIMEOUT_S, 60: seconds of ringing before auto-stop.

Ports (clock and reset first):
- CLOCK_50  in  1  system clock. One clock; all state on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SEC_TICK  in  1  one-cycle pulse from the clock datapath, high in the cycle the digits first show the new second.
- HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE  in  4 each  current time, BCD.
- KEY0  in  1  raw push button, active-low: snooze, or load minute in set mode.
- KEY1  in  1  raw push button, active-low: stop, or load hour in set mode.
- SET_ALARM  in  1  alarm-set mode switch.
- ALARM_EN  in  1  alarm enable switch.
- SET_IN  in  8  BCD value from switches, {tens, ones}.
- A_HOUR  out  8  alarm hour, BCD.
- A_MIN  out  8  alarm minute, BCD.
- BUZZER  out  1  square-wave tone.
- RINGING  out  1  high in state RING.
- SNOOZED  out  1  high in state SNOOZE.

## Operation
- Keys:
  - Each key goes through a 2-FF synchronizer, then the debouncer.
  - A press pulse (1 cycle) issues when the synced level has been low for DEBOUNCE_CYCLES consecutive cycles.
  - The next press requires a release that is stable high for DEBOUNCE_CYCLES.
- Set path, active only while SET_ALARM=1:
  - KEY1 press loads A_HOUR <= SET_IN if tens<=2, ones<=9, and the value <=0x23. Otherwise it is ignored.
  - KEY0 press loads A_MIN <= SET_IN if tens<=5 and ones<=9. Otherwise it is ignored.
- Ring FSM states: IDLE, RING, SNOOZE.
  - IDLE→RING: SEC_TICK=1, ALARM_EN=1, SET_ALARM=0, HH:MM equals A_HOUR:A_MIN, and SEC_TEN=SEC_ONE=0. Entering RING loads the ring-second counter with RING_TIMEOUT_S.
  - RING→IDLE: stop press, ALARM_EN=0, or the ring-second counter reaches 0. The counter decrements on SEC_TICK.
  - RING→SNOOZE: snooze press with no stop press in the same cycle. The snooze counter loads SNOOZE_MIN*60.
  - SNOOZE→RING: the snooze counter reaches 0. It decrements on SEC_TICK. The ring counter reloads.
  - SNOOZE→IDLE: stop press or ALARM_EN=0.
  - SET_ALARM=1 forces IDLE from any state. While SET_ALARM=1, key presses never act as stop or snooze.
- Boundary rules:
  - Simultaneous stop and snooze presses: stop wins.
  - A time match while in RING or SNOOZE is ignored.
  - A_HOUR/A_MIN changes do not disturb a running snooze.
  - The counters are wide enough for SNOOZE_MIN*60 and RING_TIMEOUT_S, sized with $clog2.
- BUZZER:
  - Toggles every TONE_DIV cycles while in RING.
  - Forced 0 in any other state.
  - The tone divider restarts at 0 on RING entry.

## Timing
- Reset values:
  - A_HOUR=0x06, A_MIN=0x30.
  - State IDLE.
  - BUZZER=0, RINGING=0, SNOOZED=0.
  - Counters and debouncers cleared; key state = released.
- Key latency: press pulse 2+DEBOUNCE_CYCLES cycles after a clean falling edge. An A_HOUR/A_MIN update is visible on the next cycle after the pulse.
- Match: RINGING rises on the cycle after the qualifying SEC_TICK.
- BUZZER is 0 on RING entry and goes 1 TONE_DIV cycles later.
- State outputs are registered and change one cycle after the causing event.
- Timeout: RING exits on the cycle after the RING_TIMEOUT_S-th SEC_TICK counted in RING.
- Snooze: re-ring on the cycle after the (SNOOZE_MIN*60)-th SEC_TICK counted in SNOOZE.
- RESET asserted mid-ring: outputs return to reset values immediately (asynchronous).

## Structure
- Shared package clock_pkg holds:
  - the ring_state_t enum (IDLE, RING, SNOOZE);
  - the alarm reset constants 8'h06 and 8'h30;
  - the BCD limits: hour max 8'h23, minute tens max 4'd5.
- One sub-module, key_debounce: synchronizer, stable counter, press pulse. Instantiated twice (KEY0, KEY1).

## Test plan
All directed tests use DEBOUNCE_CYCLES=4, TONE_DIV=3, SNOOZE_MIN=1, RING_TIMEOUT_S=5.
- Reset, then SET_ALARM=1, SET_IN=0x07, press KEY1 → A_HOUR=0x07. Then SET_IN=0x45, press KEY0 → A_MIN=0x45. Then SET_IN=0x24, press KEY1, and SET_IN=0x6A, press KEY0 → both ignored.
- Glitch: KEY0 low for 3 cycles, then high → no load. Hold low for 10 cycles → exactly one load.
- Alarm 06:30, ALARM_EN=1, time 06:30:00 with SEC_TICK → RINGING=1 next cycle. BUZZER period is 6 cycles. After 5 SEC_TICKs → IDLE, BUZZER=0.
- Snooze while ringing → SNOOZED=1, BUZZER=0. After 60 SEC_TICKs → RINGING=1 again.
- Stop and snooze pressed in the same cycle during RING → IDLE.
- While ringing: ALARM_EN=0 → IDLE next cycle. Separately, RESET pulse mid-ring → all outputs reset immediately and A_HOUR returns to 0x06.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the 24-hour BCD clock alarm logic.
package clock_pkg;

  // Alarm sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } ring_state_t;

  // Alarm time after reset: 06:30.
  localparam logic [7:0] ALARM_HOUR_RST = 8'h06;
  localparam logic [7:0] ALARM_MIN_RST  = 8'h30;

  // BCD limits for values loaded from the switch bank.
  localparam logic [7:0] HOUR_MAX     = 8'h23;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;

  // True when v is a legal BCD hour 00..23.
  function automatic logic bcd_hour_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd2) && (v[3:0] <= 4'd9) && (v <= HOUR_MAX);
  endfunction

  // True when v is a legal BCD minute 00..59.
  function automatic logic bcd_min_ok(input logic [7:0] v);
    return (v[7:4] <= MIN_TENS_MAX) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debouncer and
// a one-cycle press pulse on each accepted press (key is active-low).
module key_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             key_state_reg;  // accepted level, 1 = released
  logic [CNT_W-1:0] stable_cnt_reg;
  logic             press_reg;

  // Bring the raw key into the clock domain; idle level is released (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new level only after it differs from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles; pulse once on an accepted press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state_reg  <= 1'b1;
      stable_cnt_reg <= '0;
      press_reg      <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (sync2_reg != key_state_reg) begin
        if (stable_cnt_reg == CNT_LAST) begin
          key_state_reg  <= sync2_reg;
          stable_cnt_reg <= '0;
          press_reg      <= ~sync2_reg;
        end else begin
          stable_cnt_reg <= stable_cnt_reg + 1'b1;
        end
      end else begin
        stable_cnt_reg <= '0;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm controller: owns the alarm time registers, loads them from the
// switches in set mode, and sequences the buzzer through ring/snooze/timeout.
module alarm_scheduler
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TONE_DIV        = 25000,
  parameter int SNOOZE_MIN      = 5,
  parameter int RING_TIMEOUT_S  = 60
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       SEC_TICK,
  input  logic [3:0] HOUR_TEN,
  input  logic [3:0] HOUR_ONE,
  input  logic [3:0] MIN_TEN,
  input  logic [3:0] MIN_ONE,
  input  logic [3:0] SEC_TEN,
  input  logic [3:0] SEC_ONE,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       SET_ALARM,
  input  logic       ALARM_EN,
  input  logic [7:0] SET_IN,
  output logic [7:0] A_HOUR,
  output logic [7:0] A_MIN,
  output logic       BUZZER,
  output logic       RINGING,
  output logic       SNOOZED
);

  localparam int SNOOZE_S = SNOOZE_MIN * 60;
  localparam int RING_W   = $clog2(RING_TIMEOUT_S + 1);
  localparam int SNZ_W    = $clog2(SNOOZE_S + 1);
  localparam int TONE_W   = $clog2(TONE_DIV + 1);

  localparam logic [RING_W-1:0] RING_LOAD   = RING_W'(RING_TIMEOUT_S);
  localparam logic [SNZ_W-1:0]  SNOOZE_LOAD = SNZ_W'(SNOOZE_S);
  localparam logic [TONE_W-1:0] TONE_LAST   = TONE_W'(TONE_DIV - 1);

  // Index 0 = KEY0 (snooze / load minute), index 1 = KEY1 (stop / load hour).
  logic [1:0] key_raw;
  logic [1:0] key_press;

  assign key_raw = {KEY1, KEY0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
        .clk  (CLOCK_50),
        .rst  (RESET),
        .key  (key_raw[gi]),
        .press(key_press[gi])
      );
    end
  endgenerate

  logic snooze_press;
  logic stop_press;
  assign snooze_press = key_press[0];
  assign stop_press   = key_press[1];

  logic [7:0] a_hour_reg;
  logic [7:0] a_min_reg;

  // Load alarm time from the switches in set mode; illegal BCD is ignored.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      a_hour_reg <= ALARM_HOUR_RST;
      a_min_reg  <= ALARM_MIN_RST;
    end else if (SET_ALARM) begin
      if (stop_press && bcd_hour_ok(SET_IN)) begin
        a_hour_reg <= SET_IN;
      end
      if (snooze_press && bcd_min_ok(SET_IN)) begin
        a_min_reg <= SET_IN;
      end
    end
  end

  logic time_match;
  assign time_match = SEC_TICK && ALARM_EN && !SET_ALARM &&
                      ({HOUR_TEN, HOUR_ONE} == a_hour_reg) &&
                      ({MIN_TEN, MIN_ONE} == a_min_reg) &&
                      (SEC_TEN == 4'd0) && (SEC_ONE == 4'd0);

  ring_state_t       state_reg;
  logic [RING_W-1:0] ring_cnt_reg;
  logic [SNZ_W-1:0]  snooze_cnt_reg;
  logic [TONE_W-1:0] tone_cnt_reg;
  logic              buzzer_reg;
  logic              ringing_reg;
  logic              snoozed_reg;

  // Ring sequencer with registered outputs and the buzzer tone divider.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_reg      <= IDLE;
      ring_cnt_reg   <= '0;
      snooze_cnt_reg <= '0;
      tone_cnt_reg   <= '0;
      buzzer_reg     <= 1'b0;
      ringing_reg    <= 1'b0;
      snoozed_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (time_match) begin
            state_reg    <= RING;
            ring_cnt_reg <= RING_LOAD;
            tone_cnt_reg <= '0;
            buzzer_reg   <= 1'b0;
            ringing_reg  <= 1'b1;
            snoozed_reg  <= 1'b0;
          end
        end

        RING: begin
          // Stop has priority over snooze when both land in one cycle.
          if (SET_ALARM || stop_press || !ALARM_EN ||
              (SEC_TICK && ring_cnt_reg == RING_W'(1) && !snooze_press)) begin
            state_reg   <= IDLE;
            buzzer_reg  <= 1'b0;
            ringing_reg <= 1'b0;
            snoozed_reg <= 1'b0;
          end else if (snooze_press) begin
            state_reg      <= SNOOZE;
            snooze_cnt_reg <= SNOOZE_LOAD;
            buzzer_reg     <= 1'b0;
            ringing_reg    <= 1'b0;
            snoozed_reg    <= 1'b1;
          end else begin
            if (SEC_TICK) begin
              ring_cnt_reg <= ring_cnt_reg - 1'b1;
            end
            if (tone_cnt_reg == TONE_LAST) begin
              tone_cnt_reg <= '0;
              buzzer_reg   <= ~buzzer_reg;
            end else begin
              tone_cnt_reg <= tone_cnt_reg + 1'b1;
            end
          end
        end

        SNOOZE: begin
          if (SET_ALARM || stop_press || !ALARM_EN) begin
            state_reg   <= IDLE;
            buzzer_reg  <= 1'b0;
            ringing_reg <= 1'b0;
            snoozed_reg <= 1'b0;
          end else if (SEC_TICK) begin
            if (snooze_cnt_reg == SNZ_W'(1)) begin
              state_reg    <= RING;
              ring_cnt_reg <= RING_LOAD;
              tone_cnt_reg <= '0;
              buzzer_reg   <= 1'b0;
              ringing_reg  <= 1'b1;
              snoozed_reg  <= 1'b0;
            end else begin
              snooze_cnt_reg <= snooze_cnt_reg - 1'b1;
            end
          end
        end

        default: begin
          state_reg   <= IDLE;
          buzzer_reg  <= 1'b0;
          ringing_reg <= 1'b0;
          snoozed_reg <= 1'b0;
        end
      endcase
    end
  end

  assign A_HOUR  = a_hour_reg;
  assign A_MIN   = a_min_reg;
  assign BUZZER  = buzzer_reg;
  assign RINGING = ringing_reg;
  assign SNOOZED = snoozed_reg;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with short debounce/tone/timeouts.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sec_tick = 1'b0;
  logic [3:0] hour_ten = 4'd0, hour_one = 4'd0, min_ten = 4'd0, min_one = 4'd0;
  logic [3:0] sec_ten = 4'd0, sec_one = 4'd0;
  logic       key0 = 1'b1, key1 = 1'b1;
  logic       set_alarm = 1'b0, alarm_en = 1'b0;
  logic [7:0] set_in = 8'h00;
  logic [7:0] a_hour, a_min;
  logic       buzzer, ringing, snoozed;

  int tests_run = 0;
  int tests_failed = 0;

  alarm_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .TONE_DIV       (3),
    .SNOOZE_MIN     (1),
    .RING_TIMEOUT_S (5)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SEC_TICK (sec_tick),
    .HOUR_TEN (hour_ten),
    .HOUR_ONE (hour_one),
    .MIN_TEN  (min_ten),
    .MIN_ONE  (min_one),
    .SEC_TEN  (sec_ten),
    .SEC_ONE  (sec_one),
    .KEY0     (key0),
    .KEY1     (key1),
    .SET_ALARM(set_alarm),
    .ALARM_EN (alarm_en),
    .SET_IN   (set_in),
    .A_HOUR   (a_hour),
    .A_MIN    (a_min),
    .BUZZER   (buzzer),
    .RINGING  (ringing),
    .SNOOZED  (snoozed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] set_in;
    logic       use_key1;
    logic [7:0] exp_hour;
    logic [7:0] exp_min;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic press_keys(input logic k0, input logic k1, input int hold);
    key0 = ~k0;
    key1 = ~k1;
    repeat (hold) tick();
    key0 = 1'b1;
    key1 = 1'b1;
    repeat (10) tick();
  endtask

  task automatic set_time(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    hour_ten = hh[7:4]; hour_one = hh[3:0];
    min_ten  = mm[7:4]; min_one  = mm[3:0];
    sec_ten  = ss[7:4]; sec_one  = ss[3:0];
  endtask

  // One-cycle SEC_TICK; outputs are sampled right after the edge that saw it.
  task automatic pulse_sec();
    sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0;
  endtask

  // Present hh:mm:00 with SEC_TICK, then move the seconds off :00.
  task automatic ring_at(input logic [7:0] hh, input logic [7:0] mm);
    set_time(hh, mm, 8'h00);
    pulse_sec();
    set_time(hh, mm, 8'h01);
  endtask

  logic [5:0] bz_exp;

  initial begin
    vecs[0]  = '{8'h07, 1'b1, 8'h07, 8'h30};
    vecs[1]  = '{8'h45, 1'b0, 8'h07, 8'h45};
    vecs[2]  = '{8'h24, 1'b1, 8'h07, 8'h45};
    vecs[3]  = '{8'h6A, 1'b0, 8'h07, 8'h45};
    vecs[4]  = '{8'h23, 1'b1, 8'h23, 8'h45};
    vecs[5]  = '{8'h1A, 1'b1, 8'h23, 8'h45};
    vecs[6]  = '{8'h59, 1'b0, 8'h23, 8'h59};
    vecs[7]  = '{8'h60, 1'b0, 8'h23, 8'h59};
    vecs[8]  = '{8'h00, 1'b0, 8'h23, 8'h00};
    vecs[9]  = '{8'h06, 1'b1, 8'h06, 8'h00};
    vecs[10] = '{8'h30, 1'b0, 8'h06, 8'h30};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("reset A_HOUR", 32'(a_hour), 32'h06);
    check("reset A_MIN", 32'(a_min), 32'h30);
    check("reset outputs", {29'd0, buzzer, ringing, snoozed}, 32'd0);
    rst = 1'b0;
    tick();

    // Set path table
    set_alarm = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_in = vecs[i].set_in;
      press_keys(~vecs[i].use_key1, vecs[i].use_key1, 10);
      check($sformatf("set[%0d] A_HOUR", i), 32'(a_hour), 32'(vecs[i].exp_hour));
      check($sformatf("set[%0d] A_MIN", i), 32'(a_min), 32'(vecs[i].exp_min));
    end

    // Press latency: update visible 7 cycles after the falling edge
    set_in = 8'h11;
    key0 = 1'b0;
    repeat (6) tick();
    check("latency before", 32'(a_min), 32'h30);
    tick();
    check("latency after", 32'(a_min), 32'h11);
    repeat (3) tick();
    key0 = 1'b1;
    repeat (10) tick();

    // Glitch shorter than the debounce window
    set_in = 8'h22;
    press_keys(1'b1, 1'b0, 3);
    check("glitch no load", 32'(a_min), 32'h11);
    set_in = 8'h30;
    press_keys(1'b1, 1'b0, 10);
    check("restore A_MIN", 32'(a_min), 32'h30);

    // Match ignored while disabled
    set_alarm = 1'b0;
    alarm_en  = 1'b0;
    ring_at(8'h06, 8'h30);
    check("no ring disabled", 32'(ringing), 32'd0);

    // Ring, buzzer waveform, timeout
    alarm_en = 1'b1;
    ring_at(8'h06, 8'h30);
    check("ring entry RINGING", 32'(ringing), 32'd1);
    check("ring entry BUZZER", 32'(buzzer), 32'd0);
    bz_exp = 6'b011100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("buzzer c%0d", k), 32'(buzzer), 32'(bz_exp[k-1]));
    end
    for (int s = 1; s <= 4; s++) begin
      pulse_sec();
      tick();
    end
    check("ring before timeout", 32'(ringing), 32'd1);
    pulse_sec();
    check("timeout RINGING", 32'(ringing), 32'd0);
    check("timeout BUZZER", 32'(buzzer), 32'd0);
    tick();

    // Snooze and re-ring
    ring_at(8'h06, 8'h30);
    press_keys(1'b1, 1'b0, 10);
    check("snooze SNOOZED", 32'(snoozed), 32'd1);
    check("snooze RINGING/BUZZER", {30'd0, ringing, buzzer}, 32'd0);
    for (int s = 1; s <= 59; s++) begin
      if (s == 10) set_time(8'h06, 8'h30, 8'h00);
      pulse_sec();
      if (s == 10) set_time(8'h06, 8'h30, 8'h01);
      tick();
    end
    check("snooze before end", {30'd0, ringing, snoozed}, 32'd1);
    pulse_sec();
    check("re-ring", {30'd0, ringing, snoozed}, 32'd2);
    tick();

    // Stop press
    press_keys(1'b0, 1'b1, 10);
    check("stop", {30'd0, ringing, snoozed}, 32'd0);

    // Stop and snooze together: stop wins
    ring_at(8'h06, 8'h30);
    press_keys(1'b1, 1'b1, 10);
    check("stop+snooze", {30'd0, ringing, snoozed}, 32'd0);

    // Set mode forces idle
    ring_at(8'h06, 8'h30);
    set_alarm = 1'b1;
    tick();
    check("set forces idle", 32'(ringing), 32'd0);
    set_alarm = 1'b0;

    // Disable while ringing
    ring_at(8'h06, 8'h30);
    alarm_en = 1'b0;
    tick();
    check("disable idle", 32'(ringing), 32'd0);
    alarm_en = 1'b1;

    // Asynchronous reset mid-ring
    set_alarm = 1'b1;
    set_in = 8'h07;
    press_keys(1'b0, 1'b1, 10);
    set_alarm = 1'b0;
    ring_at(8'h07, 8'h30);
    check("pre-reset RINGING", 32'(ringing), 32'd1);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", {29'd0, buzzer, ringing, snoozed}, 32'd0);
    check("async reset A_HOUR", 32'(a_hour), 32'h06);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
